// File: rtl/stream_seq_source_pkg.sv
// Shared types for stream_seq_source.
// Holds the 2-bit sequencer state encoding.
package stream_seq_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stream_seq_source.sv
// stream_seq_source: accepts {start, step, count} on in_valid/in_ready,
// emits count elements start, start+step, ... on sOut/sOut_valid/sOut_ready,
// then signals completion on out_valid/out_ready.
// Ports: clk, nrst (async active-low), in_valid, in_ready, start, step, count,
//        sOut, sOut_valid, sOut_ready, out_valid, out_ready.
module stream_seq_source
    import stream_seq_source_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] start,
    input  logic [WIDTH-1:0] step,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] sOut,
    output logic             sOut_valid,
    input  logic             sOut_ready,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state;
    logic [WIDTH-1:0] step_q;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            sOut       <= '0;
            sOut_valid <= 1'b0;
            out_valid  <= 1'b0;
            step_q     <= '0;
            remaining  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready  <= 1'b0;
                        sOut      <= start;
                        step_q    <= step;
                        remaining <= count;
                        if (count != '0) begin
                            state      <= ST_RUN;
                            sOut_valid <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (sOut_ready) begin
                        // Last element: leave sOut showing it.
                        if (remaining == CNT_W'(1)) begin
                            state      <= ST_DONE;
                            sOut_valid <= 1'b0;
                            out_valid  <= 1'b1;
                            remaining  <= '0;
                        end else begin
                            sOut      <= sOut + step_q;
                            remaining <= remaining - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    in_ready   <= 1'b1;
                    sOut_valid <= 1'b0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_seq_source.sv
// Scoreboard bench for stream_seq_source.
// Stimulus pushes expected elements; a negedge monitor pops and compares.
module tb_stream_seq_source;

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  start;
    logic [7:0]  step;
    logic [15:0] count;
    logic [7:0]  sOut;
    logic        sOut_valid;
    logic        sOut_ready;
    logic        out_valid;
    logic        out_ready;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    stream_seq_source #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk),
        .nrst(nrst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .start(start),
        .step(step),
        .count(count),
        .sOut(sOut),
        .sOut_valid(sOut_valid),
        .sOut_ready(sOut_ready),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] s, input logic [7:0] st,
                            input logic [15:0] c);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < int'(c); i++) begin
            exp_q.push_back(v);
            v = v + st;
        end
        in_valid = 1'b1;
        start = s;
        step = st;
        count = c;
        tick();
        in_valid = 1'b0;
        start = 8'hA5;
        step = 8'h5A;
        count = 16'd9;
        chk("accept_in_ready", {31'd0, in_ready}, 0);
        if (c != 16'd0) begin
            chk("first_valid", {31'd0, sOut_valid}, 1);
            chk("first_data", {24'd0, sOut}, {24'd0, s});
        end else begin
            chk("zero_out_valid", {31'd0, out_valid}, 1);
            chk("zero_s_valid", {31'd0, sOut_valid}, 0);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        chk("done_timeout", {31'd0, out_valid}, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic finish_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_in_ready", {31'd0, in_ready}, 1);
        chk("idle_out_valid", {31'd0, out_valid}, 0);
    endtask

    // Monitor: transfers are visible at the negedge preceding the edge.
    initial begin
        logic stalled;
        logic [7:0] held;
        logic [7:0] e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && sOut_valid)
                    chk("stall_hold", {24'd0, sOut}, {24'd0, held});
                if (sOut_valid && sOut_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_elem", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("elem", {24'd0, sOut}, {24'd0, e});
                    end
                end
                stalled = sOut_valid && !sOut_ready;
                held = sOut;
            end
        end
    end

    initial begin
        logic [7:0] pat;
        nrst = 1'b0;
        in_valid = 1'b0;
        start = '0;
        step = '0;
        count = '0;
        sOut_ready = 1'b0;
        out_ready = 1'b0;

        // Reset
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_s_valid", {31'd0, sOut_valid}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_sOut", {24'd0, sOut}, 0);
        nrst = 1'b1;
        tick();

        // Basic
        sOut_ready = 1'b1;
        send_cmd(8'd5, 8'd1, 16'd4);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("basic_valid", {31'd0, sOut_valid}, 1);
            chk("basic_data", {24'd0, sOut}, 5 + i);
        end
        tick();
        chk("basic_done", {31'd0, out_valid}, 1);
        chk("basic_s_low", {31'd0, sOut_valid}, 0);
        chk("basic_last_hold", {24'd0, sOut}, 8);
        wait_done();
        finish_done();

        // Backpressure
        pat = 8'b1110_1001;
        sOut_ready = pat[0];
        send_cmd(8'd10, 8'd3, 16'd5);
        for (int k = 1; k < 8; k++) begin
            sOut_ready = pat[k];
            tick();
        end
        sOut_ready = 1'b1;
        wait_done();
        finish_done();

        // Wrap and decrement
        send_cmd(8'd254, 8'd1, 16'd3);
        wait_done();
        finish_done();
        send_cmd(8'd1, 8'hFF, 16'd3);
        wait_done();
        finish_done();

        // Zero count, completion held
        send_cmd(8'd7, 8'd1, 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("zero_hold_ov", {31'd0, out_valid}, 1);
            chk("zero_hold_ir", {31'd0, in_ready}, 0);
        end
        finish_done();

        // Abort via async reset after two transfers
        send_cmd(8'd0, 8'd1, 16'd100);
        tick();
        tick();
        nrst = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_in_ready", {31'd0, in_ready}, 1);
        chk("abort_s_valid", {31'd0, sOut_valid}, 0);
        chk("abort_sOut", {24'd0, sOut}, 0);
        tick();
        nrst = 1'b1;
        tick();
        send_cmd(8'd50, 8'd2, 16'd2);
        wait_done();
        finish_done();

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
